decode_stage: RTL
=================

# decode_stage

Registered, parametrised instruction-decode pipeline stage sitting between instruction fetch and the register-read/execute stage. Accepts raw instructions over a valid/ready handshake, decodes them into register addresses, immediate, ALU operation and usage flags, and holds the result in a single output register with backpressure. An optional register scoreboard stalls issue on RAW/WAW hazards until the writeback port retires the producing register.

## Interface
- N, 19: instruction width; must equal OPN + 3*ADDRN
- OPN, 4: opcode width
- ADDRN, 5: register address width; register count = 2**ADDRN
- VALN, 10: immediate width; VALN <= 2*ADDRN
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  1  instruction valid
- in_ready  out  1  stage can accept
- instruction  in  N  raw instruction
- flush  in  1  synchronous drop of held entry
- wb_valid  in  1  writeback retires a register
- wb_addr  in  ADDRN  retired register
- out_valid  out  1  decoded entry valid
- out_ready  in  1  downstream accepts
- opcode  out  OPN  instruction[N-1 -: OPN]
- src1, src2, src3, dst  out  ADDRN each  register addresses
- imm  out  VALN  instruction[VALN-1:0]
- alu_op  out  2  00 add, 01 sub, 10 xor, 11 mul2
- src1_use, src2_use, src3_use, dst_we, is_branch, illegal  out  1 each  usage flags

## Operation
- Fields: F1 = instruction[N-OPN-1 -: ADDRN], F2 = next ADDRN bits, F3 = instruction[ADDRN-1:0].
- Opcode decode (unused address fields and imm forced to 0, alu_op 00 unless listed):
- 0000 add / 0001 sub / 0010 xor: src1=F1, src2=F2, dst=F3, alu_op 00/01/10, src1/src2_use, dst_we.
- 0011 mul2: src1=F1, dst=F3, alu_op 11, src1_use, dst_we.
- 0100 bnez: src1=F1, imm, src1_use, is_branch.
- 0101 mv: src1=F1, dst=F3, src1_use, dst_we.
- 0110 ld: src1=F1, src2=F2, dst=F3, src1/src2_use, dst_we.
- 0111 st: src1=F1, src2=F2, src3=F3, src1/src2/src3_use.
- 1000 ldi: dst=F1, imm, dst_we.
- 1001 sti: src1=F1, imm, src1_use.
- 1010-1111: illegal=1, all use flags 0, fields 0; entry still passes downstream.
- Output register loads when issue = in_valid && in_ready && !hazard.
- in_ready = !flush && (!out_valid || out_ready).
- out_valid sets on issue; clears on out_ready without issue, or on flush.
- All outputs hold stable while out_valid && !out_ready.

## Timing
- Reset: out_valid 0, all decoded outputs 0, scoreboard all clear; in_ready 1 once rst_n high.
- Latency 1 cycle: accepted at edge k, out_valid at k+1. Throughput 1/cycle with out_ready held 1.
- Back-to-back: out_valid && out_ready && issue in same cycle replaces entry, out_valid stays 1.
- hazard (scoreboard enabled): any used source busy, or dst_we && busy[dst]. Busy bits of wb_addr are treated clear in the cycle wb_valid is high (same-cycle bypass).
- On issue with dst_we: busy[dst] set at that edge. Same-register wb_valid and issue set: set wins.
- flush: out_valid 0 next edge; if held entry had dst_we, its busy bit cleared; other busy bits untouched; no input accepted that cycle.
- rst_n low mid-operation: immediate return to reset state, held entry and busy bits lost.

## Configuration
- DECODE_SCOREBOARD_EN defined: busy-bit array, hazard stall, wb_valid/wb_addr functional.
- Not defined: no scoreboard storage, hazard tied 0, wb ports present but ignored; flush only clears out_valid.

## Test plan
- Reset then add r1,r2->r3 (0000_00001_00010_00011), out_ready 1 -> next cycle out_valid 1, src1=1, src2=2, dst=3, alu_op 00, dst_we 1.
- ldi r4,#0x155 then bnez r4,#7 -> ldi issues; bnez stalls (in_ready 1, not accepted) until wb_valid with wb_addr=4, accepted that same cycle, imm=7, is_branch 1.
- out_ready 0 with two valid inputs -> first entry held stable, in_ready 0, second accepted on cycle out_ready returns 1.
- Opcode 1100 -> illegal 1, all use flags 0, src/dst/imm 0, out_valid 1.
- Issue mv r5->r6 held with out_ready 0, assert flush -> out_valid 0 next cycle, then mv r6->r7 accepted without stall.
- Assert rst_n low while entry held and r3 busy -> out_valid 0 immediately; after release, sub using r3 issues with no stall.

Source files
------------

// File: rtl/decode_stage.sv
// decode_stage: registered instruction decode with valid/ready handshake.
// Optional busy-bit register scoreboard enabled by DECODE_SCOREBOARD_EN.
module decode_stage #(
    parameter int N     = 19,
    parameter int OPN   = 4,
    parameter int ADDRN = 5,
    parameter int VALN  = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [N-1:0]     instruction,
    input  logic             flush,
    input  logic             wb_valid,
    input  logic [ADDRN-1:0] wb_addr,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OPN-1:0]   opcode,
    output logic [ADDRN-1:0] src1,
    output logic [ADDRN-1:0] src2,
    output logic [ADDRN-1:0] src3,
    output logic [ADDRN-1:0] dst,
    output logic [VALN-1:0]  imm,
    output logic [1:0]       alu_op,
    output logic             src1_use,
    output logic             src2_use,
    output logic             src3_use,
    output logic             dst_we,
    output logic             is_branch,
    output logic             illegal
);
    localparam logic [OPN-1:0] OP_ADD  = OPN'(0);
    localparam logic [OPN-1:0] OP_SUB  = OPN'(1);
    localparam logic [OPN-1:0] OP_XOR  = OPN'(2);
    localparam logic [OPN-1:0] OP_MUL2 = OPN'(3);
    localparam logic [OPN-1:0] OP_BNEZ = OPN'(4);
    localparam logic [OPN-1:0] OP_MV   = OPN'(5);
    localparam logic [OPN-1:0] OP_LD   = OPN'(6);
    localparam logic [OPN-1:0] OP_ST   = OPN'(7);
    localparam logic [OPN-1:0] OP_LDI  = OPN'(8);
    localparam logic [OPN-1:0] OP_STI  = OPN'(9);

    logic [OPN-1:0]   op_w;
    logic [ADDRN-1:0] f1, f2, f3;
    logic [VALN-1:0]  imm_w;

    assign op_w  = instruction[N-1 -: OPN];
    assign f1    = instruction[N-OPN-1 -: ADDRN];
    assign f2    = instruction[N-OPN-ADDRN-1 -: ADDRN];
    assign f3    = instruction[ADDRN-1:0];
    assign imm_w = instruction[VALN-1:0];

    logic [ADDRN-1:0] d_src1, d_src2, d_src3, d_dst;
    logic [VALN-1:0]  d_imm;
    logic [1:0]       d_alu;
    logic             d_u1, d_u2, d_u3, d_we, d_br, d_ill;

    always_comb begin
        d_src1 = '0;
        d_src2 = '0;
        d_src3 = '0;
        d_dst  = '0;
        d_imm  = '0;
        d_alu  = 2'b00;
        d_u1   = 1'b0;
        d_u2   = 1'b0;
        d_u3   = 1'b0;
        d_we   = 1'b0;
        d_br   = 1'b0;
        d_ill  = 1'b0;
        unique case (1'b1)
            (op_w == OP_ADD), (op_w == OP_SUB), (op_w == OP_XOR): begin
                d_src1 = f1;
                d_src2 = f2;
                d_dst  = f3;
                d_alu  = op_w[1:0];
                d_u1   = 1'b1;
                d_u2   = 1'b1;
                d_we   = 1'b1;
            end
            (op_w == OP_MUL2): begin
                d_src1 = f1;
                d_dst  = f3;
                d_alu  = 2'b11;
                d_u1   = 1'b1;
                d_we   = 1'b1;
            end
            (op_w == OP_BNEZ): begin
                d_src1 = f1;
                d_imm  = imm_w;
                d_u1   = 1'b1;
                d_br   = 1'b1;
            end
            (op_w == OP_MV): begin
                d_src1 = f1;
                d_dst  = f3;
                d_u1   = 1'b1;
                d_we   = 1'b1;
            end
            (op_w == OP_LD): begin
                d_src1 = f1;
                d_src2 = f2;
                d_dst  = f3;
                d_u1   = 1'b1;
                d_u2   = 1'b1;
                d_we   = 1'b1;
            end
            (op_w == OP_ST): begin
                d_src1 = f1;
                d_src2 = f2;
                d_src3 = f3;
                d_u1   = 1'b1;
                d_u2   = 1'b1;
                d_u3   = 1'b1;
            end
            (op_w == OP_LDI): begin
                d_dst = f1;
                d_imm = imm_w;
                d_we  = 1'b1;
            end
            (op_w == OP_STI): begin
                d_src1 = f1;
                d_imm  = imm_w;
                d_u1   = 1'b1;
            end
            default: d_ill = 1'b1;
        endcase
    end

    logic hazard;
    logic issue;

    assign in_ready = !flush && (!out_valid || out_ready);
    assign issue    = in_valid && in_ready && !hazard;

`ifdef DECODE_SCOREBOARD_EN
    localparam int NREG = 2 ** ADDRN;

    logic [NREG-1:0] busy, busy_next, wb_mask, busy_live;

    always_comb begin
        wb_mask = '0;
        if (wb_valid) wb_mask[wb_addr] = 1'b1;
    end

    // a register retiring this cycle no longer blocks issue
    assign busy_live = busy & ~wb_mask;

    assign hazard = (d_u1 && busy_live[d_src1]) ||
                    (d_u2 && busy_live[d_src2]) ||
                    (d_u3 && busy_live[d_src3]) ||
                    (d_we && busy_live[d_dst]);

    always_comb begin
        busy_next = busy_live;
        if (flush && out_valid && dst_we) busy_next[dst] = 1'b0;
        if (issue && d_we) busy_next[d_dst] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_next;
    end
`else
    logic unused_wb;
    assign unused_wb = ^{wb_valid, wb_addr};
    assign hazard    = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            opcode    <= '0;
            src1      <= '0;
            src2      <= '0;
            src3      <= '0;
            dst       <= '0;
            imm       <= '0;
            alu_op    <= 2'b00;
            src1_use  <= 1'b0;
            src2_use  <= 1'b0;
            src3_use  <= 1'b0;
            dst_we    <= 1'b0;
            is_branch <= 1'b0;
            illegal   <= 1'b0;
        end else if (issue) begin
            out_valid <= 1'b1;
            opcode    <= op_w;
            src1      <= d_src1;
            src2      <= d_src2;
            src3      <= d_src3;
            dst       <= d_dst;
            imm       <= d_imm;
            alu_op    <= d_alu;
            src1_use  <= d_u1;
            src2_use  <= d_u2;
            src3_use  <= d_u3;
            dst_we    <= d_we;
            is_branch <= d_br;
            illegal   <= d_ill;
        end else if (flush || out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule
